// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: datapath width, NOP encoding, fetch FSM states, IF/ID bundle.
// No logic; the IF unit and the ID unit both import it.
// Used by the IF unit and by the ID unit.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // FILL: the ROM output does not yet correspond to a requested address.
  // RUN:  imem_rdata is the instruction at the address requested last cycle.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush, load and hold controls.
// Flush clears only valid/instr; pc/pc4 keep their last values.
// Flush has priority over load; with neither asserted the register holds.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t q_q;

  // Register update: async clear, then flush > load > hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else if (flush) begin
      q_q.valid <= 1'b0;
      q_q.instr <= NOP_INSTR;
    end else if (load) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/if_unit.sv
// Instruction fetch: owns the PC, drives a 1-cycle synchronous ROM, loads IF/ID.
// Latency: first valid IF/ID 2 edges after reset release; a redirect costs 2 bubbles.
// Stall holds everything and replays the held ROM address; redirect overrides stall.
module if_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               if_id_valid,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc4,
  output logic [31:0]        fetch_count
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  resp_pc_q, resp_pc_d;
  logic [31:0]  fetch_count_q, fetch_count_d;
  fetch_state_e state_q, state_d;

  logic   ifid_load;
  logic   ifid_flush;
  if_id_t ifid_d;
  if_id_t ifid_q;

  // Target bytes are word aligned; the low bits carry no information.
  logic redirect_lsb_unused;
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // During a plain stall re-request the held address so the ROM output
  // still matches resp_pc_q when the stall releases.
  always_comb begin
    if (stall && !redirect_valid) begin
      imem_addr = resp_pc_q[IMEM_AW+1:2];
    end else begin
      imem_addr = pc_q[IMEM_AW+1:2];
    end
  end

  // Next-state and IF/ID control: redirect > stall > normal advance.
  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    state_d       = state_q;
    fetch_count_d = fetch_count_q;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_d.valid  = 1'b1;
    ifid_d.instr  = imem_rdata;
    ifid_d.pc     = resp_pc_q;
    ifid_d.pc4    = resp_pc_q + 32'd4;

    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      state_d    = FILL;
      ifid_flush = 1'b1;
    end else if (!stall) begin
      resp_pc_d = pc_q;
      pc_d      = pc_q + 32'd4;
      state_d   = RUN;
      if (state_q == RUN) begin
        ifid_load     = 1'b1;
        fetch_count_d = fetch_count_q + 32'd1;
      end else begin
        ifid_flush = 1'b1;
      end
    end
  end

  // PC, response PC, fetch FSM and instruction counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      state_q       <= FILL;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      state_q       <= state_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign if_id_valid = ifid_q.valid;
  assign if_id_instr = ifid_q.instr;
  assign if_id_pc    = ifid_q.pc;
  assign if_id_pc4   = ifid_q.pc4;
  assign fetch_count = fetch_count_q;

endmodule
